// File: rtl/ps2_event_fifo_pkg.sv
// Shared constants, state encodings and event layout for the PS/2 event path.
// Scan-code prefixes, protocol bytes and the Pause sequence length live here.
package ps2_event_fifo_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_OVR0   = 8'h00;
  localparam logic [7:0] SC_OVR1   = 8'hFF;

  localparam logic [7:0] PAUSE_EV_CODE = 8'h77;
  localparam logic [2:0] PAUSE_SKIP    = 3'd7;
  localparam int         EV_W          = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  function automatic logic is_proto(input logic [7:0] b);
    return (b == SC_ACK)  || (b == SC_RESEND) ||
           (b == SC_ECHO) || (b == SC_BAT)    ||
           (b == SC_OVR0) || (b == SC_OVR1);
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through FIFO: head is visible on rdata while non-empty.
// Push on full is accepted only when a pop frees the slot in the same cycle.
module ps2_sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_event_fifo.sv
// Folds PS/2 scan-code bytes into {ext,brk,code} key events and queues them.
// Define PS2_REPEAT_FILTER_EN to drop typematic repeats of the last make.
module ps2_event_fifo
  import ps2_event_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      code_in,
  input  logic            code_stb,
  input  logic            code_err,
  output logic [EV_W-1:0] ev_data,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [AW:0]     ev_count,
  output logic            overflow,
  input  logic            ovf_clr
);

  state_t     state;
  state_t     nxt_state;
  logic [2:0] skip;
  logic [2:0] nxt_skip;
  ev_t        ev_q;
  ev_t        nxt_ev;
  logic       push_q;
  logic       nxt_push;
  logic       mk;
  logic       bk;
  logic       rep_hit;
  logic       full;
  logic       empty;

  always_comb begin
    nxt_state = state;
    nxt_skip  = skip;
    nxt_ev    = '0;
    nxt_push  = 1'b0;
    mk        = 1'b0;
    bk        = 1'b0;
    if (code_err) begin
      nxt_state = ST_IDLE;
    end else if (code_stb) begin
      unique case (state)
        ST_IDLE: begin
          unique case (1'b1)
            code_in == SC_EXT: nxt_state = ST_EXT;
            code_in == SC_BRK: nxt_state = ST_BRK;
            code_in == SC_PAUSE: begin
              nxt_state = ST_PAUSE;
              nxt_skip  = PAUSE_SKIP;
            end
            is_proto(code_in): nxt_state = ST_IDLE;
            default: mk = 1'b1;
          endcase
        end
        ST_EXT: begin
          unique case (1'b1)
            code_in == SC_BRK: nxt_state = ST_EXT_BRK;
            code_in == SC_EXT: nxt_state = ST_EXT;
            (code_in == SC_PAUSE) || is_proto(code_in):
              nxt_state = ST_IDLE;
            default: begin
              mk        = 1'b1;
              nxt_state = ST_IDLE;
            end
          endcase
        end
        ST_BRK: begin
          bk        = 1'b1;
          nxt_state = ST_IDLE;
        end
        ST_EXT_BRK: begin
          bk        = (code_in != SC_EXT) && (code_in != SC_BRK);
          nxt_state = ST_IDLE;
        end
        ST_PAUSE: begin
          if (skip == 3'd1) begin
            nxt_ev    = {1'b1, 1'b0, PAUSE_EV_CODE};
            nxt_push  = 1'b1;
            nxt_state = ST_IDLE;
          end else begin
            nxt_skip = skip - 3'd1;
          end
        end
        default: nxt_state = ST_IDLE;
      endcase
      if (mk) begin
        nxt_ev   = {state == ST_EXT, 1'b0, code_in};
        nxt_push = ~rep_hit;
      end
      if (bk) begin
        nxt_ev   = {state == ST_EXT_BRK, 1'b1, code_in};
        nxt_push = 1'b1;
      end
    end
  end

  // Event is registered here and written into the FIFO one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      skip   <= '0;
      ev_q   <= '0;
      push_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      skip   <= nxt_skip;
      ev_q   <= nxt_ev;
      push_q <= nxt_push;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] lm_key;
  logic       lm_vld;

  assign rep_hit = lm_vld && (lm_key == {state == ST_EXT, code_in});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lm_key <= '0;
      lm_vld <= 1'b0;
    end else if (mk) begin
      lm_key <= {state == ST_EXT, code_in};
      lm_vld <= 1'b1;
    end else if (bk && (lm_key == {state == ST_EXT_BRK, code_in})) begin
      lm_vld <= 1'b0;
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

  ps2_sync_fifo #(
    .W     (EV_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .wdata (ev_q),
    .pop   (ev_ready),
    .rdata (ev_data),
    .count (ev_count),
    .full  (full),
    .empty (empty)
  );

  assign ev_valid = ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_q && full && !(ev_valid && ev_ready)) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_event_fifo.sv
// Directed scoreboard bench for ps2_event_fifo.
// Follows PS2_REPEAT_FILTER_EN the same way the design does.
module tb_ps2_event_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] code_in;
  logic       code_stb;
  logic       code_err;
  logic [9:0] ev_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] ev_count;
  logic       overflow;
  logic       ovf_clr;

  int n_run;
  int n_fail;
  logic [9:0] sb[$];

  ps2_event_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .code_in  (code_in),
    .code_stb (code_stb),
    .code_err (code_err),
    .ev_data  (ev_data),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_count (ev_count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_in  = b;
    code_stb = 1'b1;
    @(negedge clk);
    code_stb = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    int t;
    logic [9:0] exp;
    t = 0;
    while (!ev_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    exp = sb.pop_front();
    if (!ev_valid) begin
      check({tag, "_timeout"}, 32'(ev_valid), 32'd1);
    end else begin
      check(tag, 32'(ev_data), 32'(exp));
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) pop_check(tag);
    repeat (4) @(negedge clk);
    check({tag, "_empty"}, 32'(ev_count), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    n_run    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    code_in  = 8'h00;
    code_stb = 1'b0;
    code_err = 1'b0;
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_data", 32'(ev_data), 32'd0);
    check("rst_count", 32'(ev_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    send(8'h1C);
    sb.push_back(10'h01C);
    check("t1_lat1", 32'(ev_valid), 32'd0);
    @(negedge clk);
    check("t1_lat2", 32'(ev_valid), 32'd1);
    send(8'hF0);
    send(8'h1C);
    sb.push_back(10'h11C);
    drain("t1");

    send(8'hE0); send(8'h75);
    sb.push_back(10'h275);
    send(8'hE0); send(8'hF0); send(8'h75);
    sb.push_back(10'h375);
    send(8'hE0); send(8'hE0); send(8'h75);
    sb.push_back(10'h275);
    drain("t2");

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    sb.push_back(10'h277);
    drain("t3_pause");
    send(8'h1C);
    sb.push_back(10'h01C);
    drain("t3_idle");

    for (int i = 0; i < 9; i++) begin
      b = 8'(16 + i);
      send(b);
      if (i < 8) sb.push_back({2'b00, b});
    end
    repeat (2) @(negedge clk);
    check("t4_full_cnt", 32'(ev_count), 32'd8);
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_head", 32'(ev_data), 32'(sb[0]));
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    @(negedge clk);
    code_in  = 8'h30;
    code_stb = 1'b1;
    @(negedge clk);
    code_stb = 1'b0;
    ev_ready = 1'b1;
    check("t4_pp_head", 32'(ev_data), 32'(sb.pop_front()));
    sb.push_back(10'h030);
    @(negedge clk);
    ev_ready = 1'b0;
    check("t4_pp_cnt", 32'(ev_count), 32'd8);
    check("t4_pp_ovf", 32'(overflow), 32'd0);
    drain("t4");

    send(8'hF0);
    @(negedge clk);
    code_err = 1'b1;
    @(negedge clk);
    code_err = 1'b0;
    send(8'h1C);
    sb.push_back(10'h01C);
    send(8'hFA);
    send(8'hAA);
    send(8'hF0);
    @(negedge clk);
    code_in  = 8'h2A;
    code_stb = 1'b1;
    code_err = 1'b1;
    @(negedge clk);
    code_stb = 1'b0;
    code_err = 1'b0;
    send(8'h2A);
    sb.push_back(10'h02A);
    drain("t5");

    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
    sb.push_back(10'h01C);
    sb.push_back(10'h11C);
    sb.push_back(10'h01C);
`else
    sb.push_back(10'h01C);
    sb.push_back(10'h01C);
    sb.push_back(10'h01C);
    sb.push_back(10'h11C);
    sb.push_back(10'h01C);
`endif
    drain("t6");

    send(8'h33);
    send(8'hE0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_rst_cnt", 32'(ev_count), 32'd0);
    check("t7_rst_valid", 32'(ev_valid), 32'd0);
    rst_n = 1'b1;
    send(8'h75);
    sb.push_back(10'h075);
    drain("t7");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
